// File: rtl/sdp_pingpong_ctrl_pkg.sv
// Shared constants and types for the ping-pong double-buffer controller.
package sdp_pingpong_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 28;
    // Address bits inside one bank; the remaining MSB selects the bank.
    localparam int BANK_AW        = DEF_ADDR_WIDTH - 1;
    // Tile lengths run 1..2**BANK_AW, so they need the full address width.
    localparam int LEN_W          = DEF_ADDR_WIDTH;

    // Bank index: 0 = lower half of the RAM, 1 = upper half.
    typedef logic bank_t;

endpackage : sdp_pingpong_ctrl_pkg

// File: rtl/sdp_pingpong_ctrl_if.sv
// Producer and consumer streams of the ping-pong controller.
// Handshake: a word transfers on a rising clk edge where valid && ready are
// both high; the sender holds valid and its payload stable until that edge,
// and ready may depend combinationally on controller state only.
interface sdp_pingpong_ctrl_if #(
    parameter int DATA_WIDTH = sdp_pingpong_ctrl_pkg::DEF_DATA_WIDTH
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  flush;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    // Producer/consumer side (the testbench or the surrounding datapath).
    modport master (
        output wr_valid, wr_data, flush, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last
    );

    // Controller side.
    modport slave (
        input  wr_valid, wr_data, flush, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last
    );
endinterface : sdp_pingpong_ctrl_if

// File: rtl/sdp_pingpong_ctrl_pp_bank_status.sv
// Full flag and stored tile length for one RAM bank.
// set_i and clr_i never arrive together: set needs an empty bank, clear a
// full one.
module pp_bank_status
    import sdp_pingpong_ctrl_pkg::*;
#(
    parameter int LEN_BITS = LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_i,
    input  logic                clr_i,
    input  logic [LEN_BITS-1:0] len_i,
    output logic                full_o,
    output logic [LEN_BITS-1:0] len_o
);

    logic                full_q;
    logic [LEN_BITS-1:0] len_q;

    // Record the closing tile's length and mark the bank full; free it once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            len_q  <= '0;
        end else if (set_i) begin
            full_q <= 1'b1;
            len_q  <= len_i;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign len_o  = len_q;

endmodule : pp_bank_status

// File: rtl/sdp_pingpong_ctrl.sv
// Ping-pong controller for a simple dual-port RAM with an asynchronous read
// port. The producer fills one bank while the consumer drains the other.
module sdp_pingpong_ctrl
    import sdp_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TILE_LEN   = 2 ** (ADDR_WIDTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    sdp_pingpong_ctrl_if.slave    bus,
    output logic [1:0]            bank_full,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_data_o_r
);

    localparam int                  CNT_W    = ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(TILE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] FULL_LEN = ADDR_WIDTH'(TILE_LEN);

    bank_t                 wr_bank_q, wr_bank_d;
    bank_t                 rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]      wr_cnt_q,  wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q,  rd_cnt_d;

    logic [1:0]            full_w;
    logic [ADDR_WIDTH-1:0] len_w [2];
    logic [1:0]            set_w;
    logic [1:0]            clr_w;

    logic                  accept;
    logic                  close;
    logic [ADDR_WIDTH-1:0] close_len;
    logic [ADDR_WIDTH-1:0] cur_len;
    logic                  rd_fire;

    // Handshake decode: a tile closes on its last word or on a flush that
    // has at least one word to close (an empty flush is dropped).
    always_comb begin
        accept    = bus.wr_valid && !full_w[wr_bank_q];
        close     = (accept && (wr_cnt_q == LAST_IDX)) ||
                    (bus.flush && ((wr_cnt_q != '0) || accept));
        close_len = (accept && (wr_cnt_q == LAST_IDX))
                    ? FULL_LEN
                    : {1'b0, wr_cnt_q} + ADDR_WIDTH'(accept);
        cur_len   = len_w[rd_bank_q];
        rd_fire   = full_w[rd_bank_q] && bus.rd_ready;

        bus.wr_ready = !full_w[wr_bank_q];
        bus.rd_valid = full_w[rd_bank_q];
        bus.rd_data  = ram_data_o_r;
        bus.rd_last  = full_w[rd_bank_q] &&
                       ({1'b0, rd_cnt_q} == (cur_len - ADDR_WIDTH'(1)));

        ram_wr_en    = accept;
        ram_wr_addr  = {wr_bank_q, wr_cnt_q};
        ram_data_i   = bus.wr_data;
        ram_rd_addr  = {rd_bank_q, rd_cnt_q};
        bank_full    = full_w;
    end

    // Next-state for the write/read counters, bank pointers and flag strobes.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        set_w     = 2'b00;
        clr_w     = 2'b00;

        if (close) begin
            wr_cnt_d          = '0;
            wr_bank_d         = ~wr_bank_q;
            set_w[wr_bank_q]  = 1'b1;
        end else if (accept) begin
            wr_cnt_d          = wr_cnt_q + CNT_W'(1);
        end

        if (rd_fire) begin
            if (bus.rd_last) begin
                rd_cnt_d          = '0;
                rd_bank_d         = ~rd_bank_q;
                clr_w[rd_bank_q]  = 1'b1;
            end else begin
                rd_cnt_d          = rd_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and bank-pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    pp_bank_status #(.LEN_BITS(ADDR_WIDTH)) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .set_i  (set_w[0]),
        .clr_i  (clr_w[0]),
        .len_i  (close_len),
        .full_o (full_w[0]),
        .len_o  (len_w[0])
    );

    pp_bank_status #(.LEN_BITS(ADDR_WIDTH)) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .set_i  (set_w[1]),
        .clr_i  (clr_w[1]),
        .len_i  (close_len),
        .full_o (full_w[1]),
        .len_o  (len_w[1])
    );

endmodule : sdp_pingpong_ctrl

// File: tb/tb_sdp_pingpong_ctrl.sv
// Directed bench for sdp_pingpong_ctrl with a 4-bit address, 4-word tiles
// and a behavioural asynchronous-read RAM.
module tb_sdp_pingpong_ctrl;

    localparam int AW = 4;
    localparam int DW = 28;
    localparam int TL = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    bank_full;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_data_i;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_data_o_r;
    logic [DW-1:0] mem [2**AW];

    int n_cmp;
    int n_err;
    logic [DW-1:0] exp_q [$];

    sdp_pingpong_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    sdp_pingpong_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TILE_LEN   (TL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .bank_full    (bank_full),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_data_i   (ram_data_i),
        .ram_rd_addr  (ram_rd_addr),
        .ram_data_o_r (ram_data_o_r)
    );

    // Clock and RAM model: synchronous write, asynchronous read.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_data_i;
    end

    assign ram_data_o_r = mem[ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.rd_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One accepted producer word, optionally with flush on the same cycle.
    task automatic write_word(input logic [DW-1:0] d, input int addr, input logic fl);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.flush    = fl;
        #1;
        check("wr_ready", 32'(bus.wr_ready), 32'd1);
        check("wr_en",    32'(ram_wr_en),    32'd1);
        check("wr_addr",  32'(ram_wr_addr),  32'(addr));
        tick();
        bus.wr_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // One consumed word with expected address, data and last flag.
    task automatic read_word(input int addr, input logic [DW-1:0] d, input logic last);
        bus.rd_ready = 1'b1;
        #1;
        check("rd_valid", 32'(bus.rd_valid), 32'd1);
        check("rd_addr",  32'(ram_rd_addr),  32'(addr));
        check("rd_data",  32'(bus.rd_data),  32'(d));
        check("rd_last",  32'(bus.rd_last),  32'(last));
        tick();
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.flush    = 1'b0;
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;

        // Reset state.
        #2;
        check("rst_wr_ready",  32'(bus.wr_ready), 32'd1);
        check("rst_rd_valid",  32'(bus.rd_valid), 32'd0);
        check("rst_rd_last",   32'(bus.rd_last),  32'd0);
        check("rst_wr_en",     32'(ram_wr_en),    32'd0);
        check("rst_bank_full", 32'(bank_full),    32'd0);
        check("rst_rd_addr",   32'(ram_rd_addr),  32'd0);
        tick();
        rst = 1'b0;

        // Fill bank 0, first word appears at the read port the next cycle.
        for (int i = 0; i < 4; i++) write_word(28'hA0 + 28'(i), i, 1'b0);
        check("t1_bank_full", 32'(bank_full),     32'b01);
        check("t1_rd_valid",  32'(bus.rd_valid),  32'd1);
        check("t1_rd_addr",   32'(ram_rd_addr),   32'd0);
        check("t1_rd_data",   32'(bus.rd_data),   32'hA0);

        // Fill bank 1, producer then stalls.
        for (int i = 0; i < 4; i++) write_word(28'hB0 + 28'(i), 8 + i, 1'b0);
        check("t2_wr_ready",  32'(bus.wr_ready), 32'd0);
        check("t2_bank_full", 32'(bank_full),    32'b11);
        bus.wr_valid = 1'b1;
        #1;
        check("t2_no_accept", 32'(ram_wr_en),    32'd0);
        bus.wr_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) read_word(i, 28'hA0 + 28'(i), i == 3);
        check("t2_freed",     32'(bus.wr_ready), 32'd1);
        check("t2_bank_full", 32'(bank_full),    32'b10);
        write_word(28'hC0, 0, 1'b0);

        // Drain bank 1, then close a two-word tile in bank 0 by flush.
        for (int i = 0; i < 4; i++) read_word(8 + i, 28'hB0 + 28'(i), i == 3);
        check("t3_empty",     32'(bus.rd_valid), 32'd0);
        write_word(28'hC1, 1, 1'b0);
        bus.flush = 1'b1;
        #1;
        check("t3_flush_we",  32'(ram_wr_en),    32'd0);
        tick();
        bus.flush = 1'b0;
        check("t3_bank_full", 32'(bank_full),    32'b01);
        read_word(0, 28'hC0, 1'b0);
        read_word(1, 28'hC1, 1'b1);
        check("t3_drained",   32'(bank_full),    32'b00);
        write_word(28'hD0, 8, 1'b0);

        // Empty flush is dropped; flush on the last word makes one full tile.
        do_reset();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t5_empty_flush", 32'(bank_full),  32'b00);
        for (int i = 0; i < 3; i++) write_word(28'hE0 + 28'(i), i, 1'b0);
        write_word(28'hE3, 3, 1'b1);
        check("t5_one_tile",  32'(bank_full),    32'b01);
        for (int i = 0; i < 4; i++) read_word(i, 28'hE0 + 28'(i), i == 3);
        check("t5_no_extra",  32'(bus.rd_valid), 32'd0);
        write_word(28'hE4, 8, 1'b0);

        // Continuous streaming on both sides, three tiles.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            bus.wr_valid = (k < 12);
            bus.wr_data  = 28'h5000 + 28'(k);
            bus.rd_ready = 1'b1;
            #1;
            if (k < 12) begin
                check("st_wr_ready", 32'(bus.wr_ready), 32'd1);
                check("st_wr_addr",  32'(ram_wr_addr),  32'(((k / 4) % 2) * 8 + (k % 4)));
                exp_q.push_back(bus.wr_data);
            end
            if (k >= 4) begin
                check("st_rd_valid", 32'(bus.rd_valid), 32'd1);
                if (exp_q.size() > 0)
                    check("st_rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                check("st_rd_last",  32'(bus.rd_last),  32'(((k - 4) % 4) == 3));
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("st_end_full",  32'(bank_full),   32'b00);

        // Asynchronous reset mid-tile with bank 1 full.
        do_reset();
        for (int i = 0; i < 4; i++) write_word(28'hF0 + 28'(i), i, 1'b0);
        for (int i = 0; i < 4; i++) write_word(28'h70 + 28'(i), 8 + i, 1'b0);
        for (int i = 0; i < 4; i++) read_word(i, 28'hF0 + 28'(i), i == 3);
        write_word(28'h80, 0, 1'b0);
        write_word(28'h81, 1, 1'b0);
        check("t6_pre_full",  32'(bank_full),    32'b10);
        check("t6_pre_addr",  32'(ram_rd_addr),  32'd8);
        #1;
        rst = 1'b1;
        #1;
        check("t6_full",      32'(bank_full),    32'b00);
        check("t6_rd_valid",  32'(bus.rd_valid), 32'd0);
        check("t6_rd_addr",   32'(ram_rd_addr),  32'd0);
        check("t6_wr_addr",   32'(ram_wr_addr),  32'd0);
        check("t6_wr_ready",  32'(bus.wr_ready), 32'd1);
        tick();
        rst = 1'b0;
        write_word(28'h90, 0, 1'b0);
        check("t6_post_rdv",  32'(bus.rd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sdp_pingpong_ctrl
